// File: rtl/instruction_fetch.sv
// Instruction fetch stage: a three-state FSM (IDLE, FETCH, HOLD) that owns
// the PC, issues reads to instruction memory, and presents the fetched word
// with its PC+1 to the IF/ID latch.
//
// Ports:
//   enable        - clock; all state updates on its rising edge
//   reset         - asynchronous, active-high reset
//   PC_write      - 0 stalls the stage (hazard unit), 1 lets it advance
//   branch_taken  - branch redirect request (highest priority)
//   branch_target - branch destination
//   jump          - jump redirect request
//   jump_target   - jump destination
//   imem_req      - instruction memory read request
//   imem_addr     - instruction memory address
//   imem_rdata    - instruction memory read data
//   imem_ready    - imem_rdata is valid for imem_addr this cycle
//   pc_out        - current PC
//   instruc_out   - fetched word for the IF/ID latch
//   PC_plus_1_out - address of the fetched word plus 1
//   fetch_valid   - instruc_out / PC_plus_1_out hold a real instruction
module instruction_fetch #(
  parameter int unsigned PC_WIDTH = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                enable,
  input  logic                reset,
  input  logic                PC_write,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [31:0]         instruc_out,
  output logic [PC_WIDTH-1:0] PC_plus_1_out,
  output logic                fetch_valid
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_plus_1_q, pc_plus_1_d;
  logic                valid_q, valid_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic [PC_WIDTH-1:0] pc_inc;

  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_inc          = pc_q + PcOne;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_plus_1_d = pc_plus_1_q;
    valid_d     = valid_q;

    if (redirect) begin
      // Redirect wins in every state and over a stall; any data returned
      // this cycle belongs to the wrong path and is dropped.
      pc_d    = redirect_target;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StFetch;
        end
        StFetch: begin
          if (imem_ready) begin
            instr_d     = imem_rdata;
            pc_plus_1_d = pc_inc;
            valid_d     = 1'b1;
            if (PC_write) begin
              pc_d = pc_inc;
            end else begin
              // Word is captured but the PC waits until the stall lifts.
              state_d = StHold;
            end
          end else if (PC_write) begin
            // Wait state: emit a bubble, keep re-requesting the same PC.
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        StHold: begin
          if (PC_write) begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge enable or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      instr_q     <= NOP_WORD;
      pc_plus_1_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_plus_1_q <= pc_plus_1_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req      = (state_q == StFetch);
  assign imem_addr     = pc_q;
  assign pc_out        = pc_q;
  assign instruc_out   = instr_q;
  assign PC_plus_1_out = pc_plus_1_q;
  assign fetch_valid   = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a table of per-cycle stimulus and
// hand-derived expected outputs, fed through an expected-result queue, plus a
// hand-written asynchronous-reset sequence.
module tb_instruction_fetch;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        PC_write;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic        jump;
  logic [9:0]  jump_target;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [9:0]  pc_out;
  logic [31:0] instruc_out;
  logic [9:0]  PC_plus_1_out;
  logic        fetch_valid;

  instruction_fetch #(
    .PC_WIDTH(10),
    .NOP_WORD(Nop)
  ) dut (
    .enable       (clk),
    .reset        (reset),
    .PC_write     (PC_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc_out       (pc_out),
    .instruc_out  (instruc_out),
    .PC_plus_1_out(PC_plus_1_out),
    .fetch_valid  (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'hA000_0000 + {22'b0, a};
  endfunction

  // Zero-wait memory: every address holds word(addr).
  always_comb imem_rdata = word(imem_addr);

  typedef struct {
    logic        pw;
    logic        rdy;
    logic        br;
    logic [9:0]  bt;
    logic        jp;
    logic [9:0]  jt;
    logic [9:0]  e_pc;
    logic [31:0] e_ins;
    logic [9:0]  e_p1;
    logic        e_val;
    logic        e_req;
  } vec_t;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] ins;
    logic [9:0]  p1;
    logic        val;
    logic        req;
  } exp_t;

  function automatic vec_t mk(input logic pw, input logic rdy, input logic br,
                              input logic [9:0] bt, input logic jp, input logic [9:0] jt,
                              input logic [9:0] e_pc, input logic [31:0] e_ins,
                              input logic [9:0] e_p1, input logic e_val, input logic e_req);
    vec_t v;
    v.pw = pw; v.rdy = rdy; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_p1 = e_p1; v.e_val = e_val; v.e_req = e_req;
    return v;
  endfunction

  localparam int NumVec = 25;
  vec_t vecs[NumVec];
  exp_t exp_q[$];

  int n_pass;
  int n_total;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, req);
  endtask

  task automatic check_all(input int idx, input exp_t e);
    check("pc_out", idx, {22'b0, pc_out}, {22'b0, e.pc});
    check("imem_addr", idx, {22'b0, imem_addr}, {22'b0, e.pc});
    check("instruc_out", idx, instruc_out, e.ins);
    check("PC_plus_1_out", idx, {22'b0, PC_plus_1_out}, {22'b0, e.p1});
    check("fetch_valid", idx, {31'b0, fetch_valid}, {31'b0, e.val});
    check("imem_req", idx, {31'b0, imem_req}, {31'b0, e.req});
  endtask

  initial begin
    exp_t e;
    n_pass = 0;
    n_total = 0;

    //              pw  rdy br  bt      jp  jt      e_pc    e_ins          e_p1    val req
    // Sequential fetch from 0
    vecs[0]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h000, Nop,           10'h000, 0, 1);
    vecs[1]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h001, word(10'h000), 10'h001, 1, 1);
    vecs[2]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h002, word(10'h001), 10'h002, 1, 1);
    vecs[3]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h003, word(10'h002), 10'h003, 1, 1);
    vecs[4]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h004, word(10'h003), 10'h004, 1, 1);
    vecs[5]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h005, word(10'h004), 10'h005, 1, 1);
    // Two wait states at pc=5
    vecs[6]  = mk(1, 0, 0, 10'h0,   0, 10'h0,   10'h005, Nop,           10'h005, 0, 1);
    vecs[7]  = mk(1, 0, 0, 10'h0,   0, 10'h0,   10'h005, Nop,           10'h005, 0, 1);
    vecs[8]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h006, word(10'h005), 10'h006, 1, 1);
    vecs[9]  = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h007, word(10'h006), 10'h007, 1, 1);
    vecs[10] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h008, word(10'h007), 10'h008, 1, 1);
    // Stall while fetching pc=8: capture, HOLD twice, release
    vecs[11] = mk(0, 1, 0, 10'h0,   0, 10'h0,   10'h008, word(10'h008), 10'h009, 1, 0);
    vecs[12] = mk(0, 1, 0, 10'h0,   0, 10'h0,   10'h008, word(10'h008), 10'h009, 1, 0);
    vecs[13] = mk(0, 1, 0, 10'h0,   0, 10'h0,   10'h008, word(10'h008), 10'h009, 1, 0);
    vecs[14] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h009, word(10'h008), 10'h009, 1, 1);
    vecs[15] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h00A, word(10'h009), 10'h00A, 1, 1);
    // Stall with memory not ready: everything holds, no bubble
    vecs[16] = mk(0, 0, 0, 10'h0,   0, 10'h0,   10'h00A, word(10'h009), 10'h00A, 1, 1);
    // Branch and jump together under stall: branch wins
    vecs[17] = mk(0, 1, 1, 10'h040, 1, 10'h100, 10'h040, Nop,           10'h00A, 0, 1);
    vecs[18] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h041, word(10'h040), 10'h041, 1, 1);
    // Jump to top of address space, then wrap
    vecs[19] = mk(1, 1, 0, 10'h0,   1, 10'h3FF, 10'h3FF, Nop,           10'h041, 0, 1);
    vecs[20] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h000, word(10'h3FF), 10'h000, 1, 1);
    vecs[21] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h001, word(10'h000), 10'h001, 1, 1);
    // Redirect while in HOLD
    vecs[22] = mk(0, 1, 0, 10'h0,   0, 10'h0,   10'h001, word(10'h001), 10'h002, 1, 0);
    vecs[23] = mk(0, 1, 1, 10'h200, 0, 10'h0,   10'h200, Nop,           10'h002, 0, 1);
    vecs[24] = mk(1, 1, 0, 10'h0,   0, 10'h0,   10'h201, word(10'h200), 10'h201, 1, 1);

    reset = 1'b1;
    PC_write = 1'b1;
    branch_taken = 1'b0;
    branch_target = '0;
    jump = 1'b0;
    jump_target = '0;
    imem_ready = 1'b1;

    // Reset values before any clock edge, and again with the clock running.
    e = '{pc: 10'h0, ins: Nop, p1: 10'h0, val: 1'b0, req: 1'b0};
    #2;
    check_all(100, e);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all(101, e);

    // Reset is released just after an edge; that edge is the first, so the
    // request appears after the second and valid data after the third.
    reset = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      PC_write      = vecs[i].pw;
      imem_ready    = vecs[i].rdy;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].bt;
      jump          = vecs[i].jp;
      jump_target   = vecs[i].jt;
      exp_q.push_back('{pc: vecs[i].e_pc, ins: vecs[i].e_ins, p1: vecs[i].e_p1,
                        val: vecs[i].e_val, req: vecs[i].e_req});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_all(i, e);
    end

    // Async reset pulse while waiting in FETCH; ready during IDLE is ignored.
    @(negedge clk);
    PC_write = 1'b1;
    imem_ready = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    @(posedge clk);
    #1;
    check_all(200, '{pc: 10'h201, ins: Nop, p1: 10'h201, val: 1'b0, req: 1'b1});
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all(201, '{pc: 10'h0, ins: Nop, p1: 10'h0, val: 1'b0, req: 1'b0});
    imem_ready = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all(202, '{pc: 10'h0, ins: Nop, p1: 10'h0, val: 1'b0, req: 1'b1});
    @(posedge clk);
    #1;
    check_all(203, '{pc: 10'h1, ins: word(10'h0), p1: 10'h1, val: 1'b1, req: 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 10, SHALL set the width of the PC and of all instruction addresses.
REQ-002 Parameter NOP_WORD, default 32'h00000000, SHALL set the instruction word output during bubbles.
REQ-003 Port enable, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: reset SHALL be asynchronous and active-high.
REQ-005 Port PC_write, input, 1: 0 SHALL stall the stage (hazard unit); 1 SHALL allow the stage to advance.
REQ-006 Port branch_taken, input, 1: branch redirect request.
REQ-007 Port branch_target, input, PC_WIDTH: branch destination.
REQ-008 Port jump, input, 1: jump redirect request.
REQ-009 Port jump_target, input, PC_WIDTH: jump destination.
REQ-010 Port imem_req, output, 1: instruction memory read request.
REQ-011 Port imem_addr, output, PC_WIDTH: instruction memory address.
REQ-012 Port imem_rdata, input, 32: instruction memory read data.
REQ-013 Port imem_ready, input, 1: imem_rdata is valid for imem_addr this cycle.
REQ-014 Port pc_out, output, PC_WIDTH: current PC.
REQ-015 Port instruc_out, output, 32: fetched word, fed to the IF/ID latch.
REQ-016 Port PC_plus_1_out, output, PC_WIDTH: address of the fetched word plus 1, fed to the IF/ID latch.
REQ-017 Port fetch_valid, output, 1: instruc_out and PC_plus_1_out hold a real instruction.

Function
REQ-018 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-019 IDLE SHALL drive imem_req=0 and SHALL go to FETCH on the next edge unconditionally.
REQ-020 FETCH SHALL drive imem_req=1 and imem_addr=pc_out combinationally.
REQ-021 FETCH with imem_ready=0, no redirect: PC SHALL hold, the state SHALL stay FETCH, and the outputs SHALL become a bubble (instruc_out=NOP_WORD, fetch_valid=0).
REQ-022 FETCH with imem_ready=1, PC_write=1, no redirect: the stage SHALL capture instruc_out<=imem_rdata, set PC_plus_1_out<=pc+1 and fetch_valid<=1, set pc<=pc+1, and stay in FETCH; the fetch latency SHALL be one cycle with a zero-wait memory.
REQ-023 FETCH with imem_ready=1, PC_write=0, no redirect: the stage SHALL capture as in REQ-022, SHALL NOT advance pc, and SHALL go to HOLD.
REQ-024 HOLD SHALL drive imem_req=0.
REQ-025 HOLD with PC_write=0: all outputs SHALL hold.
REQ-026 HOLD with PC_write=1: the stage SHALL set pc<=pc+1 and go to FETCH, and the outputs SHALL hold for that edge.
REQ-027 FETCH with PC_write=0 and imem_ready=0: the outputs SHALL hold (no bubble inserted) and pc SHALL hold.
REQ-028 Redirect priority SHALL be branch_taken > jump > sequential.
REQ-029 A redirect SHALL act in every state and SHALL override PC_write=0.
REQ-030 On a redirect the stage SHALL set pc<=target, instruc_out<=NOP_WORD and fetch_valid<=0, SHALL discard any imem_rdata returned that cycle, and SHALL go to FETCH.
REQ-031 PC arithmetic SHALL be modulo 2^PC_WIDTH: pc=10'h3FF advancing SHALL give 10'h000, and PC_plus_1_out SHALL give 10'h000.
REQ-032 Redirect targets SHALL be used unmodified, with no offset or alignment applied.
REQ-033 PC_plus_1_out SHALL always equal the address that produced instruc_out, plus 1, modulo 2^PC_WIDTH.

Reset
REQ-034 While reset=1, the stage SHALL be in IDLE with pc=0, instruc_out=NOP_WORD, PC_plus_1_out=0, fetch_valid=0 and imem_req=0, regardless of the clock.
REQ-035 Reset asserted mid-fetch or in HOLD SHALL abort the fetch immediately; the memory response SHALL be ignored.
REQ-036 After reset deasserts, the first imem_req SHALL be asserted on the second rising edge (IDLE for one cycle).

Verification
REQ-037 Sequential fetch: reset, then a zero-wait memory with word = 32'hA000_0000 + addr -> fetch_valid rises on the 3rd edge with instruc_out=32'hA000_0000 and PC_plus_1_out=1; the next edge gives 32'hA000_0001 and PC_plus_1_out=2.
REQ-038 Wait states: imem_ready low for 2 cycles at pc=5 -> two bubble cycles (fetch_valid=0, instruc_out=NOP_WORD), then instruc_out=word(5), PC_plus_1_out=6, and pc stays at 5 throughout the wait.
REQ-039 Stall: PC_write=0 for 3 cycles while fetching pc=8 -> word(8) is held in HOLD and pc=8 during the stall; after release, pc=9 and then word(9) is fetched; no instruction is lost or duplicated at the output.
REQ-040 Simultaneous redirect: branch_taken=1 (target 10'h040) and jump=1 (target 10'h100) with PC_write=0 -> pc=10'h040, fetch_valid=0, and the next fetch is at 10'h040.
REQ-041 Wrap-around: jump to 10'h3FF, then fetch -> PC_plus_1_out=0 and the next imem_addr=0.
REQ-042 Async reset mid-wait: reset pulses between edges while in FETCH with imem_ready=0 -> outputs go to reset values immediately, and a later imem_ready=1 before the IDLE exit is ignored.
